instr_mem_responder: RTL and testbench



---
 rtl/instr_mem_responder_pkg.sv | 22 ++
 rtl/instr_mem_responder_if.sv | 33 +++
 rtl/instr_rsp_fifo.sv | 56 +++++
 rtl/instr_mem_responder.sv | 133 +++++++++++++
 tb/tb_instr_mem_responder.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_mem_responder_pkg.sv
// instr_mem_responder_pkg
// Shared constants and response type for the instruction memory responder.
// Items:
//   INSTR_MEM_DEPTH_WORDS  default instruction array size in 32-bit words
//   INSTR_MEM_LATENCY      default accept-to-FIFO-write latency in cycles
//   INSTR_RESP_DEPTH       default response FIFO depth / credit count
//   NOP_INSTR              word returned for faulting fetches
//   instr_rsp_t            one response: instruction word plus error flag
package instr_mem_responder_pkg;

  localparam int INSTR_MEM_DEPTH_WORDS = 1024;
  localparam int INSTR_MEM_LATENCY     = 2;
  localparam int INSTR_RESP_DEPTH      = 4;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } instr_rsp_t;

endpackage

// File: rtl/instr_mem_responder_if.sv
// instr_mem_responder_if
// Fetch-side request/response bus between instruction fetch and the memory
// responder.
// Signals:
//   instr_req_ip   fetch request valid
//   instr_addr_ip  byte address of the requested instruction
//   instr_gnt_op   request accepted when high together with instr_req_ip
//   instr_valid_op response available at FIFO head
//   instr_data_op  response instruction word
//   instr_err_op   response error flag
//   rsp_ready_ip   fetch consumes the head response on the clock edge
// Modports: master (fetch side), slave (memory responder side).
interface instr_mem_responder_if;

  logic        instr_req_ip;
  logic [31:0] instr_addr_ip;
  logic        instr_gnt_op;
  logic        instr_valid_op;
  logic [31:0] instr_data_op;
  logic        instr_err_op;
  logic        rsp_ready_ip;

  modport master (
    output instr_req_ip, instr_addr_ip, rsp_ready_ip,
    input  instr_gnt_op, instr_valid_op, instr_data_op, instr_err_op
  );

  modport slave (
    input  instr_req_ip, instr_addr_ip, rsp_ready_ip,
    output instr_gnt_op, instr_valid_op, instr_data_op, instr_err_op
  );

endinterface

// File: rtl/instr_rsp_fifo.sv
// instr_rsp_fifo
// Synchronous FIFO of instr_rsp_t entries with asynchronous active-low reset.
// Ports:
//   clock, reset_n  clock and async active-low reset
//   push, push_data write an entry on the rising edge
//   pop             retire the head entry on the rising edge (caller gates
//                   with !empty)
//   head            current head entry
//   empty, count    occupancy status
// The caller guarantees no push when full (credit limited).
module instr_rsp_fifo
  import instr_mem_responder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         push,
  input  instr_rsp_t                   push_data,
  input  logic                         pop,
  output instr_rsp_t                   head,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);

  instr_rsp_t      entries [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) entries[wr_ptr] <= push_data;
  end

  assign head  = entries[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/instr_mem_responder.sv
// instr_mem_responder
// Memory-side responder for instruction fetch. Grants word-read requests
// while response credits remain, reads the instruction array at accept,
// delays the result LATENCY cycles and queues it in an in-order response
// FIFO that fetch drains with rsp_ready_ip. A load port preloads images.
// Ports:
//   clock, reset_n        clock and async active-low reset
//   mem_en                enables new grants (in-flight work still drains)
//   load_we_ip            preload write enable
//   load_addr_ip          preload byte address
//   load_data_ip          preload word
//   bus                   fetch request/response bus (slave side)
// Optional feature macro: INSTR_MEM_ERR_CHECK_EN
//   defined   - misaligned or out-of-range fetches return NOP with err=1,
//               out-of-range load writes are dropped
//   undefined - low address bits ignored, indices wrap, err tied 0
module instr_mem_responder
  import instr_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = INSTR_MEM_DEPTH_WORDS,
  parameter int LATENCY     = INSTR_MEM_LATENCY,
  parameter int RESP_DEPTH  = INSTR_RESP_DEPTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  mem_en,
  input  logic                  load_we_ip,
  input  logic [31:0]           load_addr_ip,
  input  logic [31:0]           load_data_ip,
  instr_mem_responder_if.slave  bus
);

  localparam int IW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(RESP_DEPTH + 1);

  logic [31:0]      mem [DEPTH_WORDS];
  logic [CW-1:0]    outstanding;
  logic [CW-1:0]    fifo_count;
  logic             accept;
  logic             pop;
  logic             fifo_empty;
  logic [IW-1:0]    rd_idx;
  logic [IW-1:0]    wr_idx;
  logic             rd_bad;
  logic             wr_bad;
  instr_rsp_t       rd_rsp;
  instr_rsp_t       head;
  logic [LATENCY-1:0] pipe_valid;
  instr_rsp_t       pipe_rsp [LATENCY];

  assign rd_idx = bus.instr_addr_ip[IW+1:2];
  assign wr_idx = load_addr_ip[IW+1:2];

`ifdef INSTR_MEM_ERR_CHECK_EN
  logic unused_bits;
  assign rd_bad      = (|bus.instr_addr_ip[1:0]) | (|bus.instr_addr_ip[31:IW+2]);
  assign wr_bad      = |load_addr_ip[31:IW+2];
  assign unused_bits = ^load_addr_ip[1:0];
`else
  logic unused_bits;
  assign rd_bad      = 1'b0;
  assign wr_bad      = 1'b0;
  assign unused_bits = ^{bus.instr_addr_ip[31:IW+2], bus.instr_addr_ip[1:0],
                         load_addr_ip[31:IW+2], load_addr_ip[1:0], head.err};
`endif

  // Grant depends only on registered credit state, never on the request.
  assign bus.instr_gnt_op = reset_n & mem_en & (outstanding < CW'(RESP_DEPTH));
  assign accept           = bus.instr_req_ip & bus.instr_gnt_op;
  assign pop              = ~fifo_empty & bus.rsp_ready_ip;

  assign rd_rsp.data = rd_bad ? NOP_INSTR : mem[rd_idx];
  assign rd_rsp.err  = rd_bad;

  // Array read is captured into the pipeline at the accept edge, so a load
  // write to the same word on that edge is seen only by later reads.
  always_ff @(posedge clock) begin
    if (load_we_ip && !wr_bad) mem[wr_idx] <= load_data_ip;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pipe_valid <= '0;
      for (int i = 0; i < LATENCY; i++) pipe_rsp[i] <= '0;
    end else begin
      pipe_valid[0] <= accept;
      pipe_rsp[0]   <= rd_rsp;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_rsp[i]   <= pipe_rsp[i-1];
      end
    end
  end

  // Credits cover both in-flight pipeline entries and FIFO residents.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      outstanding <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: ;
      endcase
    end
  end

  instr_rsp_fifo #(
    .DEPTH (RESP_DEPTH)
  ) u_rsp_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (pipe_valid[LATENCY-1]),
    .push_data (pipe_rsp[LATENCY-1]),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clock) begin
    if (reset_n) assert (fifo_count <= outstanding);
  end

  assign bus.instr_valid_op = ~fifo_empty;
  assign bus.instr_data_op  = fifo_empty ? 32'h0 : head.data;
`ifdef INSTR_MEM_ERR_CHECK_EN
  assign bus.instr_err_op   = ~fifo_empty & head.err;
`else
  assign bus.instr_err_op   = 1'b0;
`endif

endmodule

// File: tb/tb_instr_mem_responder.sv
module tb_instr_mem_responder;
  import instr_mem_responder_pkg::*;

  localparam int DW  = INSTR_MEM_DEPTH_WORDS;
  localparam int LAT = INSTR_MEM_LATENCY;
  localparam int RD  = INSTR_RESP_DEPTH;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_en = 1'b0;
  logic        load_we = 1'b0;
  logic [31:0] load_addr = '0;
  logic [31:0] load_data = '0;

  instr_mem_responder_if bus ();

  instr_mem_responder dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .mem_en       (mem_en),
    .load_we_ip   (load_we),
    .load_addr_ip (load_addr),
    .load_data_ip (load_data),
    .bus          (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int pops   = 0;

  logic [32:0] sb [$];
  logic [31:0] model_mem [DW];

  function automatic logic [32:0] model_rsp(input logic [31:0] a);
`ifdef INSTR_MEM_ERR_CHECK_EN
    if (a[1:0] != 2'b00 || a >= 32'(4*DW)) return {1'b1, NOP_INSTR};
`endif
    return {1'b0, model_mem[a[11:2]]};
  endfunction

  // Scoreboard: expectations pushed at accept, checked at pop.
  always @(negedge clock) begin
    logic [32:0] exp;
    if (!reset_n) begin
      sb.delete();
    end else begin
      if (bus.instr_valid_op && bus.rsp_ready_ip) begin
        pops++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp: got data=%h err=%b, required no response",
                   bus.instr_data_op, bus.instr_err_op);
        end else begin
          exp = sb.pop_front();
          if ({bus.instr_err_op, bus.instr_data_op} !== exp) begin
            errors++;
            $display("FAIL rsp_order: got err=%b data=%h, required err=%b data=%h",
                     bus.instr_err_op, bus.instr_data_op, exp[32], exp[31:0]);
          end
        end
      end
      if (bus.instr_req_ip && bus.instr_gnt_op) sb.push_back(model_rsp(bus.instr_addr_ip));
      if (load_we) begin
`ifdef INSTR_MEM_ERR_CHECK_EN
        if (load_addr < 32'(4*DW)) model_mem[load_addr[11:2]] = load_data;
`else
        model_mem[load_addr[11:2]] = load_data;
`endif
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_rsp(output logic [31:0] d, output logic e, output bit ok);
    ok = 1'b0; d = '0; e = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bus.instr_valid_op) begin
        d = bus.instr_data_op; e = bus.instr_err_op; ok = 1'b1;
        break;
      end
    end
    step();
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (sb.size() == 0 && !bus.instr_valid_op) begin
        ok = 1'b1;
        break;
      end
    end
    step();
  endtask

  task automatic issue_and_wait(input logic [31:0] a, output logic [31:0] d,
                                output logic e, output bit ok);
    bus.instr_req_ip = 1'b1; bus.instr_addr_ip = a;
    step();
    bus.instr_req_ip = 1'b0;
    wait_rsp(d, e, ok);
  endtask

  task automatic load_word(input int idx, input logic [31:0] val);
    load_we = 1'b1; load_addr = 32'(idx * 4); load_data = val;
    step();
    load_we = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; mem_en = 1'b1;
    bus.instr_req_ip = 1'b0; bus.instr_addr_ip = '0; bus.rsp_ready_ip = 1'b0;
    #1;
    checks += 4;
    if (bus.instr_gnt_op !== 1'b0)   begin errors++; $display("FAIL reset_gnt: got %b required 0", bus.instr_gnt_op); end
    if (bus.instr_valid_op !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", bus.instr_valid_op); end
    if (bus.instr_data_op !== 32'h0) begin errors++; $display("FAIL reset_data: got %h required 0", bus.instr_data_op); end
    if (bus.instr_err_op !== 1'b0)   begin errors++; $display("FAIL reset_err: got %b required 0", bus.instr_err_op); end
    repeat (2) step();
    reset_n = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.instr_gnt_op !== 1'b1) begin errors++; $display("FAIL first_gnt: got %b required 1", bus.instr_gnt_op); end
    step();
  endtask

  task automatic preload_image();
    for (int i = 0; i < 16; i++) load_word(i, 32'hA000_0000 + 32'(i));
    load_word(5, 32'hDEAD_BEEF);
    load_word(3, 32'h2222_2222);
  endtask

  task automatic test_single();
    bus.rsp_ready_ip = 1'b1;
    bus.instr_req_ip = 1'b1; bus.instr_addr_ip = 32'h14;
    @(negedge clock);
    checks++;
    if (bus.instr_gnt_op !== 1'b1) begin errors++; $display("FAIL single_gnt: got %b required 1", bus.instr_gnt_op); end
    step();
    bus.instr_req_ip = 1'b0;
    repeat (LAT) @(negedge clock);
    checks++;
    if (bus.instr_valid_op !== 1'b0) begin errors++; $display("FAIL latency_early: got valid %b required 0", bus.instr_valid_op); end
    @(negedge clock);
    checks += 3;
    if (bus.instr_valid_op !== 1'b1) begin errors++; $display("FAIL latency_valid: got %b required 1", bus.instr_valid_op); end
    if (bus.instr_data_op !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_data: got %h required deadbeef", bus.instr_data_op); end
    if (bus.instr_err_op !== 1'b0) begin errors++; $display("FAIL single_err: got %b required 0", bus.instr_err_op); end
    repeat (3) step();
    checks++;
    if (dut.outstanding !== '0) begin errors++; $display("FAIL single_credit: got %0d required 0", dut.outstanding); end
  endtask

  task automatic test_backpressure();
    int  grants = 0;
    int  w = 0;
    int  p0;
    bit  ok;
    bus.rsp_ready_ip = 1'b0;
    bus.instr_req_ip = 1'b1; bus.instr_addr_ip = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (bus.instr_gnt_op) begin grants++; w++; end
      step();
      bus.instr_addr_ip = 32'(w * 4);
    end
    checks += 2;
    if (grants != RD) begin errors++; $display("FAIL bp_grants: got %0d required %0d", grants, RD); end
    @(negedge clock);
    if (bus.instr_gnt_op !== 1'b0) begin errors++; $display("FAIL bp_gnt_full: got %b required 0", bus.instr_gnt_op); end
    step();
    p0 = pops;
    bus.rsp_ready_ip = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.instr_gnt_op !== 1'b0) begin errors++; $display("FAIL bp_gnt_before_pop: got %b required 0", bus.instr_gnt_op); end
    step();
    @(negedge clock);
    checks++;
    if (bus.instr_gnt_op !== 1'b1) begin errors++; $display("FAIL bp_gnt_after_pop: got %b required 1", bus.instr_gnt_op); end
    step();
    bus.instr_req_ip = 1'b0;
    wait_drain(ok);
    checks += 2;
    if (!ok) begin errors++; $display("FAIL bp_drain: got timeout required drained"); end
    if (pops - p0 != RD + 1) begin errors++; $display("FAIL bp_pop_count: got %0d required %0d", pops - p0, RD + 1); end
  endtask

  task automatic test_same_edge();
    logic [31:0] d; logic e; bit ok;
    bus.rsp_ready_ip = 1'b1;
    bus.instr_req_ip = 1'b1; bus.instr_addr_ip = 32'hC;
    load_we = 1'b1; load_addr = 32'hC; load_data = 32'h1111_1111;
    @(negedge clock);
    checks++;
    if (bus.instr_gnt_op !== 1'b1) begin errors++; $display("FAIL same_edge_gnt: got %b required 1", bus.instr_gnt_op); end
    step();
    bus.instr_req_ip = 1'b0; load_we = 1'b0;
    wait_rsp(d, e, ok);
    checks++;
    if (!ok || d !== 32'h2222_2222) begin errors++; $display("FAIL same_edge_old: got %h (seen %b) required 22222222", d, ok); end
    issue_and_wait(32'hC, d, e, ok);
    checks++;
    if (!ok || d !== 32'h1111_1111) begin errors++; $display("FAIL same_edge_new: got %h (seen %b) required 11111111", d, ok); end
  endtask

  task automatic test_mem_en();
    int p0; bit ok;
    bus.rsp_ready_ip = 1'b0;
    bus.instr_req_ip = 1'b1; bus.instr_addr_ip = 32'(6 * 4);
    step();
    bus.instr_addr_ip = 32'(7 * 4);
    step();
    mem_en = 1'b0;
    bus.instr_addr_ip = 32'(8 * 4);
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      checks++;
      if (bus.instr_gnt_op !== 1'b0) begin errors++; $display("FAIL mem_en_gnt: got %b required 0 (cycle %0d)", bus.instr_gnt_op, c); end
      step();
    end
    p0 = pops;
    bus.instr_req_ip = 1'b0; bus.rsp_ready_ip = 1'b1;
    wait_drain(ok);
    checks += 2;
    if (!ok) begin errors++; $display("FAIL mem_en_drain: got timeout required drained"); end
    if (pops - p0 != 2) begin errors++; $display("FAIL mem_en_delivered: got %0d required 2", pops - p0); end
    mem_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    int p0;
    bus.rsp_ready_ip = 1'b0;
    for (int i = 8; i < 11; i++) begin
      bus.instr_req_ip = 1'b1; bus.instr_addr_ip = 32'(i * 4);
      step();
    end
    bus.instr_req_ip = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.instr_valid_op !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %b required 1", bus.instr_valid_op); end
    #2 reset_n = 1'b0;
    #1;
    checks += 3;
    if (bus.instr_gnt_op !== 1'b0)   begin errors++; $display("FAIL mid_reset_gnt: got %b required 0", bus.instr_gnt_op); end
    if (bus.instr_valid_op !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b required 0", bus.instr_valid_op); end
    if (bus.instr_data_op !== 32'h0) begin errors++; $display("FAIL mid_reset_data: got %h required 0", bus.instr_data_op); end
    repeat (2) step();
    reset_n = 1'b1;
    bus.rsp_ready_ip = 1'b1;
    p0 = pops;
    repeat (10) step();
    checks += 3;
    if (pops != p0) begin errors++; $display("FAIL stale_rsp: got %0d responses required 0", pops - p0); end
    if (bus.instr_valid_op !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b required 0", bus.instr_valid_op); end
    if (dut.outstanding !== '0) begin errors++; $display("FAIL post_reset_credit: got %0d required 0", dut.outstanding); end
  endtask

  task automatic test_addr_check();
    logic [31:0] d; logic e; bit ok;
    logic [31:0] exp_d; logic exp_e;
    bus.rsp_ready_ip = 1'b1;
`ifdef INSTR_MEM_ERR_CHECK_EN
    exp_d = NOP_INSTR; exp_e = 1'b1;
`else
    exp_d = 32'hA000_0001; exp_e = 1'b0;
`endif
    issue_and_wait(32'h6, d, e, ok);
    checks++;
    if (!ok || d !== exp_d || e !== exp_e) begin errors++; $display("FAIL misaligned: got data=%h err=%b required data=%h err=%b", d, e, exp_d, exp_e); end
`ifdef INSTR_MEM_ERR_CHECK_EN
    exp_d = NOP_INSTR; exp_e = 1'b1;
`else
    exp_d = 32'hA000_0000; exp_e = 1'b0;
`endif
    issue_and_wait(32'(4 * DW), d, e, ok);
    checks++;
    if (!ok || d !== exp_d || e !== exp_e) begin errors++; $display("FAIL out_of_range: got data=%h err=%b required data=%h err=%b", d, e, exp_d, exp_e); end
    load_we = 1'b1; load_addr = 32'(4 * DW + 4); load_data = 32'h5555_5555;
    step();
    load_we = 1'b0;
`ifdef INSTR_MEM_ERR_CHECK_EN
    exp_d = 32'hA000_0001;
`else
    exp_d = 32'h5555_5555;
`endif
    issue_and_wait(32'h4, d, e, ok);
    checks++;
    if (!ok || d !== exp_d || e !== 1'b0) begin errors++; $display("FAIL load_wrap: got data=%h err=%b required data=%h err=0", d, e, exp_d); end
  endtask

  task automatic test_back_to_back();
    int g = 0; bit ok;
    bus.rsp_ready_ip = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.instr_req_ip = 1'b1; bus.instr_addr_ip = 32'((i + 8) * 4);
      @(negedge clock);
      if (bus.instr_gnt_op) g++;
      step();
    end
    bus.instr_req_ip = 1'b0;
    wait_drain(ok);
    checks += 2;
    if (g != 8) begin errors++; $display("FAIL b2b_grants: got %0d required 8", g); end
    if (!ok) begin errors++; $display("FAIL b2b_drain: got timeout required drained"); end
  endtask

  initial begin
    test_reset();
    preload_image();
    test_single();
    test_backpressure();
    test_same_edge();
    test_mem_en();
    test_reset_mid();
    test_addr_check();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d pending required 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
